// File: rtl/beam_pkg.sv
// beam_pkg: shared FFT word layout, widths and detector states for the beamforming datapath
package beam_pkg;
  localparam int FFT_W = 28;
  localparam int FFT_HALF = 14;
  localparam int ADDR_W = 10;
  localparam int PWR_W = 29;
  typedef struct packed {
    logic signed [FFT_HALF-1:0] re;
    logic signed [FFT_HALF-1:0] im;
  } fft_word_t;
  typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DECIDE, COMPLETE} pd_state_t;
endpackage

// File: rtl/cmag_sq.sv
// cmag_sq: combinational |X|^2 of one FFT word as an unsigned 29-bit power
module cmag_sq
  import beam_pkg::*;
(
  input  fft_word_t        x,
  output logic [PWR_W-1:0] pwr
);
  logic signed [FFT_W-1:0] re, im;
  assign re = FFT_W'(x.re);
  assign im = FFT_W'(x.im);
  // each square is non-negative and at most 2^26, so the 29-bit sum cannot overflow
  assign pwr = PWR_W'(re * re) + PWR_W'(im * im);
endmodule

// File: rtl/peak_bin_detect.sv
// peak_bin_detect: scans channel-1 FFT bins after each frame, publishes the max-power bin
// and holds the read address there for the weight block.
module peak_bin_detect #(
  parameter int          ADDR_W     = 10,
  parameter int          BIN_LO     = 1,
  parameter int          BIN_HI     = 511,
  parameter int          RD_LAT     = 2,
  parameter logic [28:0] PWR_THRESH = 29'd4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fftdone,
  input  logic [beam_pkg::FFT_W-1:0]   ramq1,
  output logic [ADDR_W-1:0]            rdaddr1,
  output logic [ADDR_W-1:0]            maxbin,
  output logic [beam_pkg::PWR_W-1:0]   maxpwr,
  output logic                         detectdone,
  output logic                         nosignal,
  output logic                         busy
);
  import beam_pkg::*;
  pd_state_t         state_q;
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] cmp_bin_q, run_bin_q;
  logic [PWR_W-1:0]  run_pwr_q, pwr;
  logic [7:0]        drain_q;
  cmag_sq u_mag (.x(ramq1), .pwr(pwr));
  assign busy = (state_q == SCAN) || (state_q == DRAIN) || (state_q == DECIDE);
  // vld_q tags each issued address; its oldest bit marks the cycle ramq1 holds cmp_bin_q's data
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      vld_q      <= '0;
      cmp_bin_q  <= '0;
      run_bin_q  <= '0;
      run_pwr_q  <= '0;
      drain_q    <= '0;
      rdaddr1    <= '0;
      maxbin     <= '0;
      maxpwr     <= '0;
      detectdone <= 1'b0;
      nosignal   <= 1'b0;
    end else begin
      detectdone <= 1'b0;
      nosignal   <= 1'b0;
      vld_q      <= RD_LAT'({vld_q, state_q == SCAN});
      if (vld_q[RD_LAT-1]) begin
        cmp_bin_q <= cmp_bin_q + ADDR_W'(1);
        if (pwr > run_pwr_q) begin
          run_pwr_q <= pwr;
          run_bin_q <= cmp_bin_q;
        end
      end
      case (state_q)
        IDLE, COMPLETE: if (fftdone) begin
          state_q   <= SCAN;
          rdaddr1   <= ADDR_W'(BIN_LO);
          cmp_bin_q <= ADDR_W'(BIN_LO);
          run_bin_q <= ADDR_W'(BIN_LO);
          run_pwr_q <= '0;
        end
        SCAN: if (rdaddr1 == ADDR_W'(BIN_HI)) begin
          state_q <= DRAIN;
          drain_q <= '0;
        end else rdaddr1 <= rdaddr1 + ADDR_W'(1);
        DRAIN: if (drain_q == 8'(RD_LAT - 1)) state_q <= DECIDE;
          else drain_q <= drain_q + 8'd1;
        DECIDE: if (run_pwr_q >= PWR_THRESH) begin
          maxbin     <= run_bin_q;
          maxpwr     <= run_pwr_q;
          rdaddr1    <= run_bin_q;
          detectdone <= 1'b1;
          state_q    <= COMPLETE;
        end else begin
          nosignal <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_peak_bin_detect.sv
// tb_peak_bin_detect: table-driven frame scans against a 2-cycle RAM model, plus reset and rescan corners
module tb_peak_bin_detect;
  logic        clk = 1'b0, reset = 1'b0, fftdone = 1'b0;
  logic [27:0] ramq1 = '0;
  logic [9:0]  rdaddr1, maxbin, a1 = '0;
  logic [28:0] maxpwr;
  logic        detectdone, nosignal, busy;
  logic [27:0] mem [0:1023];
  int          tests = 0, fails = 0;
  longint      exp_bin = 0, exp_pwr = 0;
  typedef struct {
    int bg_re, bg_im;
    int b0, re0, im0;
    int b1, re1, im1;
    bit det;
    int bin, pwr;
  } vec_t;
  vec_t tv [7];
  peak_bin_detect dut (
    .clk(clk), .reset(reset), .fftdone(fftdone), .ramq1(ramq1), .rdaddr1(rdaddr1),
    .maxbin(maxbin), .maxpwr(maxpwr), .detectdone(detectdone), .nosignal(nosignal), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    a1    <= rdaddr1;
    ramq1 <= mem[a1];
  end
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic load(input vec_t v);
    for (int i = 0; i < 1024; i++) mem[i] = {14'(v.bg_re), 14'(v.bg_im)};
    if (v.b0 >= 0) mem[v.b0] = {14'(v.re0), 14'(v.im0)};
    if (v.b1 >= 0) mem[v.b1] = {14'(v.re1), 14'(v.im1)};
  endtask
  task automatic run_check(input string nm, input vec_t v, input int mid);
    int lat;
    load(v);
    @(negedge clk); fftdone = 1'b1;
    @(negedge clk); fftdone = 1'b0;
    chk({nm, " busy_start"}, busy, 1);
    for (lat = 1; lat < 700; lat++) begin
      if (lat == mid) fftdone = 1'b1;
      @(negedge clk);
      fftdone = 1'b0;
      if (detectdone || nosignal) break;
    end
    if (v.det) begin
      exp_bin = v.bin;
      exp_pwr = v.pwr;
    end
    chk({nm, " latency"}, lat, 514);
    chk({nm, " detectdone"}, detectdone, v.det);
    chk({nm, " nosignal"}, nosignal, !v.det);
    chk({nm, " maxbin"}, maxbin, exp_bin);
    chk({nm, " maxpwr"}, maxpwr, exp_pwr);
    chk({nm, " rdaddr1"}, rdaddr1, v.det ? exp_bin : 511);
    @(negedge clk);
    chk({nm, " pulse_end"}, {detectdone, nosignal}, 0);
    repeat (3) @(negedge clk);
    chk({nm, " rdaddr1_held"}, rdaddr1, v.det ? exp_bin : 511);
    chk({nm, " busy_end"}, busy, 0);
  endtask
  initial begin
    vec_t v7;
    int pulses;
    tv[0] = '{10, 10, 40, 1000, -500, -1, 0, 0, 1'b1, 40, 1250000};
    tv[1] = '{10, 10, 100, 300, 400, 300, 300, 400, 1'b1, 100, 250000};
    tv[2] = '{20, 0, 0, 8191, 8191, -1, 0, 0, 1'b0, 0, 0};
    tv[3] = '{10, 10, 511, -8192, -8192, -1, 0, 0, 1'b1, 511, 134217728};
    tv[4] = '{0, 0, 5, 64, 0, -1, 0, 0, 1'b1, 5, 4096};
    tv[5] = '{0, 0, 9, 63, 10, 600, 1000, 1000, 1'b0, 0, 0};
    tv[6] = '{1, 1, 1, 0, -100, -1, 0, 0, 1'b1, 1, 10000};
    v7    = '{10, 10, 7, 500, 0, -1, 0, 0, 1'b1, 7, 250000};
    repeat (3) @(negedge clk);
    chk("reset rdaddr1", rdaddr1, 0);
    chk("reset maxbin", maxbin, 0);
    chk("reset maxpwr", maxpwr, 0);
    chk("reset pulses", {detectdone, nosignal}, 0);
    chk("reset busy", busy, 0);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) run_check($sformatf("vec%0d", i), tv[i], 0);
    run_check("rescan_bin7", v7, 100);
    load(tv[0]);
    @(negedge clk); fftdone = 1'b1;
    @(negedge clk); fftdone = 1'b0;
    repeat (199) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst rdaddr1", rdaddr1, 0);
    chk("midrst maxbin", maxbin, 0);
    chk("midrst maxpwr", maxpwr, 0);
    chk("midrst pulses", {detectdone, nosignal}, 0);
    chk("midrst busy", busy, 0);
    reset = 1'b1;
    pulses = 0;
    repeat (600) begin
      @(negedge clk);
      if (detectdone || nosignal) pulses++;
    end
    chk("midrst no_pulse", pulses, 0);
    exp_bin = 0;
    exp_pwr = 0;
    run_check("after_rst", tv[0], 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
